// File: rtl/fsm_input_conditioner.sv
// Synchronizes and debounces board switches and the step button, producing a clean switch
// vector, one-cycle step pulses and a wrapping step counter. Optional feature macro: AUTO_STEP_EN.
module fsm_input_conditioner #(
    parameter int SW_WIDTH        = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8,
    parameter int AUTO_PERIOD     = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SW_WIDTH-1:0] sw_raw,
    input  logic                btn_raw,
    input  logic                auto_mode,
    output logic [SW_WIDTH-1:0] sw_out,
    output logic                ctrl_out,
    output logic                sw_busy,
    output logic [CNT_W-1:0]    step_count
);

    // The button rides in the top bit so it shares the switch synchronizer and debouncer.
    localparam int NB  = SW_WIDTH + 1;
    localparam int BTN = SW_WIDTH;
    localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0]    s1_q, s1_d;
    logic [NB-1:0]    s2_q, s2_d;
    logic [NB-1:0]    stable_q, stable_d;
    logic [DBW-1:0]   cnt_q [NB];
    logic [DBW-1:0]   cnt_d [NB];
    logic             sw_busy_q, sw_busy_d;
    logic [1:0]       prime_q, prime_d;
    logic             armed_q, armed_d;
    logic             pending_q, pending_d;
    logic             ctrl_q, ctrl_d;
    logic [CNT_W-1:0] step_count_q, step_count_d;
    logic             btn_rise;
    logic             step_req;

`ifdef AUTO_STEP_EN
    localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

    logic [AW-1:0] auto_cnt_q, auto_cnt_d;
    logic          auto_req;
`else
    logic          unused_auto;
    assign unused_auto = auto_mode & (AUTO_PERIOD > 0);
`endif

    always_comb begin
        s1_d      = {btn_raw, sw_raw};
        s2_d      = s1_q;
        stable_d  = stable_q;
        sw_busy_d = 1'b0;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DBW'(1);
                end
            end
        end
        for (int i = 0; i < SW_WIDTH; i++) begin
            sw_busy_d = sw_busy_d | (cnt_d[i] != '0);
        end
    end

    // A button already held when reset releases is not a press: rises only count once the
    // synchronized button has been seen low after the synchronizer holds real samples.
    always_comb begin
        prime_d  = {prime_q[0], 1'b1};
        armed_d  = armed_q | (prime_q[1] & ~s2_q[BTN]);
        btn_rise = armed_q & stable_d[BTN] & ~stable_q[BTN];
`ifdef AUTO_STEP_EN
        auto_cnt_d = '0;
        auto_req   = 1'b0;
        if (auto_mode) begin
            if (auto_cnt_q == AUTO_LAST) begin
                auto_req = 1'b1;
            end else begin
                auto_cnt_d = auto_cnt_q + AW'(1);
            end
        end
        step_req = auto_mode ? auto_req : btn_rise;
`else
        step_req = btn_rise;
`endif
        ctrl_d       = (pending_q | step_req) & ~sw_busy_q;
        pending_d    = (pending_q | step_req) & ~ctrl_d;
        step_count_d = step_count_q + CNT_W'(ctrl_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q         <= '0;
            s2_q         <= '0;
            stable_q     <= '0;
            cnt_q        <= '{default: '0};
            sw_busy_q    <= 1'b0;
            prime_q      <= '0;
            armed_q      <= 1'b0;
            pending_q    <= 1'b0;
            ctrl_q       <= 1'b0;
            step_count_q <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            stable_q     <= stable_d;
            cnt_q        <= cnt_d;
            sw_busy_q    <= sw_busy_d;
            prime_q      <= prime_d;
            armed_q      <= armed_d;
            pending_q    <= pending_d;
            ctrl_q       <= ctrl_d;
            step_count_q <= step_count_d;
        end
    end

`ifdef AUTO_STEP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end
`endif

    assign sw_out     = stable_q[SW_WIDTH-1:0];
    assign ctrl_out   = ctrl_q;
    assign sw_busy    = sw_busy_q;
    assign step_count = step_count_q;

endmodule
